// File: rtl/lbuf_port_scheduler.sv
// Port scheduler for the 128 x 128-bit dual-port local buffer: arbitrates one writer and
// two readers onto SRAM ports A/B, stalls same-address collisions, and runs a zeroing sweep.
module lbuf_port_scheduler #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 128,
    parameter int STRB_W    = 8,
    parameter int DEPTH     = 128,
    parameter int WR_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_start_i,
    output logic              busy_o,
    output logic              clr_done_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i,
    input  logic              rd0_valid_i,
    output logic              rd0_ready_o,
    input  logic [ADDR_W-1:0] rd0_addr_i,
    output logic              rd0_rvalid_o,
    output logic [DATA_W-1:0] rd0_rdata_o,
    input  logic              rd1_valid_i,
    output logic              rd1_ready_o,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic              rd1_rvalid_o,
    output logic [DATA_W-1:0] rd1_rdata_o,
    output logic [ADDR_W-1:0] sram_a_o,
    output logic [ADDR_W-1:0] sram_b_o,
    output logic              sram_oea_o,
    output logic              sram_oeb_o,
    output logic [STRB_W-1:0] sram_wean_o,
    output logic [STRB_W-1:0] sram_webn_o,
    output logic [DATA_W-1:0] sram_dia_o,
    output logic [DATA_W-1:0] sram_dib_o,
    input  logic [DATA_W-1:0] sram_doa_i,
    input  logic [DATA_W-1:0] sram_dob_i
);

    // state    | meaning
    // ST_IDLE  | normal arbitration: writer/rd1 share port A, rd0 owns port B
    // ST_CLEAR | port A writes zero to address cnt_q each cycle, all requesters held off
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam int SW = $clog2(WR_STREAK + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              rd0_rvalid_q, rd1_rvalid_q;
    logic              rd1_turn;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            streak_q     <= '0;
            rd0_rvalid_q <= 1'b0;
            rd1_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            rd0_rvalid_q <= rd0_ready_o;
            rd1_rvalid_q <= rd1_ready_o;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        rd1_turn    = 1'b0;
        wr_ready_o  = 1'b0;
        rd0_ready_o = 1'b0;
        rd1_ready_o = 1'b0;
        busy_o      = 1'b0;
        clr_done_o  = 1'b0;
        sram_a_o    = '0;
        sram_dia_o  = '0;
        sram_wean_o = '1;
        sram_oea_o  = 1'b0;
        sram_b_o    = '0;
        sram_oeb_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rd1 takes port A once the writer has had WR_STREAK grants in a row
                rd1_turn    = rd1_valid_i && (streak_q == SW'(WR_STREAK));
                wr_ready_o  = wr_valid_i && !rd1_turn;
                rd1_ready_o = rd1_valid_i && !wr_ready_o
                              && !(rd0_valid_i && (rd0_addr_i == rd1_addr_i));
                rd0_ready_o = rd0_valid_i && !(wr_ready_o && (wr_addr_i == rd0_addr_i));
                if (wr_ready_o) begin
                    sram_a_o    = wr_addr_i;
                    sram_dia_o  = wr_data_i;
                    sram_wean_o = ~wr_strb_i;
                end else if (rd1_ready_o) begin
                    sram_a_o   = rd1_addr_i;
                    sram_oea_o = 1'b1;
                end
                if (rd0_ready_o) begin
                    sram_b_o   = rd0_addr_i;
                    sram_oeb_o = 1'b1;
                end
                if (!rd1_valid_i || rd1_turn || rd1_ready_o) begin
                    streak_d = '0;
                end else if (wr_ready_o) begin
                    streak_d = streak_q + SW'(1);
                end
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                busy_o      = 1'b1;
                sram_a_o    = cnt_q;
                sram_wean_o = '0;
                if (!rd1_valid_i) begin
                    streak_d = '0;
                end
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    clr_done_o = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
        endcase
    end

    assign sram_webn_o  = '1;
    assign sram_dib_o   = '0;
    assign rd0_rvalid_o = rd0_rvalid_q;
    assign rd1_rvalid_o = rd1_rvalid_q;
    assign rd0_rdata_o  = rd0_rvalid_q ? sram_dob_i : '0;
    assign rd1_rdata_o  = rd1_rvalid_q ? sram_doa_i : '0;

endmodule

// File: tb/tb_lbuf_port_scheduler.sv
// Bench for lbuf_port_scheduler: behavioural SRAM, a request-level reference model,
// directed scenarios followed by randomized traffic.
module tb_lbuf_port_scheduler;

    logic         clk;
    logic         rst_n;
    logic         clr_start, busy, clr_done;
    logic         wr_valid, wr_ready;
    logic [6:0]   wr_addr;
    logic [127:0] wr_data;
    logic [7:0]   wr_strb;
    logic         rd0_valid, rd0_ready, rd0_rvalid;
    logic [6:0]   rd0_addr;
    logic [127:0] rd0_rdata;
    logic         rd1_valid, rd1_ready, rd1_rvalid;
    logic [6:0]   rd1_addr;
    logic [127:0] rd1_rdata;
    logic [6:0]   sram_a, sram_b;
    logic         sram_oea, sram_oeb;
    logic [7:0]   sram_wean, sram_webn;
    logic [127:0] sram_dia, sram_dib, sram_doa, sram_dob;

    lbuf_port_scheduler dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_start_i(clr_start), .busy_o(busy), .clr_done_o(clr_done),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_strb_i(wr_strb), .rd0_valid_i(rd0_valid), .rd0_ready_o(rd0_ready), .rd0_addr_i(rd0_addr),
        .rd0_rvalid_o(rd0_rvalid), .rd0_rdata_o(rd0_rdata), .rd1_valid_i(rd1_valid),
        .rd1_ready_o(rd1_ready), .rd1_addr_i(rd1_addr), .rd1_rvalid_o(rd1_rvalid),
        .rd1_rdata_o(rd1_rdata), .sram_a_o(sram_a), .sram_b_o(sram_b), .sram_oea_o(sram_oea),
        .sram_oeb_o(sram_oeb), .sram_wean_o(sram_wean), .sram_webn_o(sram_webn),
        .sram_dia_o(sram_dia), .sram_dib_o(sram_dib), .sram_doa_i(sram_doa), .sram_dob_i(sram_dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port SRAM with 16-bit byte-group write enables on port A.
    logic [127:0] mem [128];
    always @(posedge clk) begin
        if (sram_oea) sram_doa <= mem[sram_a];
        if (sram_oeb) sram_dob <= mem[sram_b];
        for (int g = 0; g < 8; g++)
            if (!sram_wean[g]) mem[sram_a][g*16 +: 16] <= sram_dia[g*16 +: 16];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: buffer contents, pending responses, arbitration history.
    logic [127:0] ref_mem [128];
    int           writes_while_rd1_waits = 0;
    bit           m_clear = 0;
    int           m_cnt = 0;
    bit           er0_v = 0, er1_v = 0;
    logic [127:0] er0_d, er1_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_cycle(input logic wv, input logic [6:0] wa, input logic [127:0] wd,
                            input logic [7:0] ws, input logic r0v, input logic [6:0] r0a,
                            input logic r1v, input logic [6:0] r1a, input logic clr,
                            output logic mg_w, output logic mg_0, output logic mg_1,
                            output logic [127:0] o_r0d, output logic [127:0] o_r1d);
        logic       rd1_owed;
        logic [6:0] ea;
        logic [7:0] ewean;
        logic       eoea, eoeb;
        @(negedge clk);
        check("rd0_rvalid", rd0_rvalid, er0_v);
        check("rd0_rdata", rd0_rdata, er0_v ? er0_d : 128'(0));
        check("rd1_rvalid", rd1_rvalid, er1_v);
        check("rd1_rdata", rd1_rdata, er1_v ? er1_d : 128'(0));
        o_r0d = rd0_rdata;
        o_r1d = rd1_rdata;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd0_valid = r0v; rd0_addr = r0a; rd1_valid = r1v; rd1_addr = r1a;
        clr_start = clr;
        #1;
        mg_w = 0; mg_0 = 0; mg_1 = 0; rd1_owed = 0;
        ea = 0; ewean = 8'hFF; eoea = 0; eoeb = 0;
        if (m_clear) begin
            ea = 7'(m_cnt);
            ewean = 8'h00;
        end else begin
            rd1_owed = r1v && (writes_while_rd1_waits == 4);
            mg_w = wv && !rd1_owed;
            mg_0 = r0v && !(mg_w && wa == r0a);
            mg_1 = r1v && !mg_w && !(r0v && r0a == r1a);
            if (mg_w) begin ea = wa; ewean = ~ws; end
            else if (mg_1) begin ea = r1a; eoea = 1; end
            eoeb = mg_0;
        end
        check("wr_ready", wr_ready, mg_w);
        check("rd0_ready", rd0_ready, mg_0);
        check("rd1_ready", rd1_ready, mg_1);
        check("busy", busy, m_clear);
        check("clr_done", clr_done, m_clear && m_cnt == 127);
        check("sram_oea", sram_oea, eoea);
        check("sram_oeb", sram_oeb, eoeb);
        check("sram_wean", sram_wean, ewean);
        check("sram_webn", sram_webn, 8'hFF);
        check("sram_dib", sram_dib, 128'(0));
        if (mg_w || mg_1 || m_clear) check("sram_a", sram_a, ea);
        if (mg_0) check("sram_b", sram_b, r0a);
        if (mg_w) check("sram_dia", sram_dia, wd);
        if (m_clear) check("sram_dia_clr", sram_dia, 128'(0));
        if (sram_oeb && (sram_oea || sram_wean != 8'hFF))
            check("port_collision", sram_a == sram_b, 1'b0);
        er0_v = mg_0;
        er1_v = mg_1;
        if (mg_0) er0_d = ref_mem[r0a];
        if (mg_1) er1_d = ref_mem[r1a];
        if (mg_w)
            for (int g = 0; g < 8; g++)
                if (ws[g]) ref_mem[wa][g*16 +: 16] = wd[g*16 +: 16];
        if (!r1v || rd1_owed || mg_1) writes_while_rd1_waits = 0;
        else if (mg_w) writes_while_rd1_waits++;
        if (m_clear) begin
            ref_mem[m_cnt] = '0;
            if (m_cnt == 127) begin m_clear = 0; m_cnt = 0; end
            else m_cnt++;
        end else if (clr) begin
            m_clear = 1;
            m_cnt = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         gw, g0, g1;
        logic [127:0] d0, d1, da, db, nw;
        int           mw, dut_wr, grant_at, busy_cnt, done_addr;
        logic         r1p, pw, p0, p1;
        logic [6:0]   pwa, p0a, p1a;
        logic [127:0] pwd;
        logic [7:0]   pws;

        rst_n = 0; clr_start = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        rd0_valid = 0; rd0_addr = 0; rd1_valid = 0; rd1_addr = 0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_rvalid0", rd0_rvalid, 1'b0);
        check("rst_rvalid1", rd1_rvalid, 1'b0);
        check("rst_rdata0", rd0_rdata, 128'(0));
        check("rst_rdata1", rd1_rdata, 128'(0));
        check("rst_readies", {wr_ready, rd0_ready, rd1_ready}, 3'b000);
        check("rst_wean", sram_wean, 8'hFF);
        check("rst_webn", sram_webn, 8'hFF);
        check("rst_oe", {sram_oea, sram_oeb}, 2'b00);
        check("rst_addr", {sram_a, sram_b}, 14'h0);
        check("rst_dia", sram_dia, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // Full write then rd0 readback
        da = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_cycle(1, 7'd5, da, 8'hFF, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t1_wr_ready", wr_ready, 1'b1);
        do_cycle(0, 0, 0, 0, 1, 7'd5, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t1_rd0_ready", rd0_ready, 1'b1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t1_rd0_rvalid", rd0_rvalid, 1'b1);
        check("t1_rd0_rdata", d0, da);

        // Partial strobe over an all-ones word
        nw = rnd128();
        do_cycle(1, 7'd9, '1, 8'hFF, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        do_cycle(1, 7'd9, nw, 8'h01, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        do_cycle(0, 0, 0, 0, 1, 7'd9, 0, 0, 0, gw, g0, g1, d0, d1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t2_strb_rdata", d0, {{112{1'b1}}, nw[15:0]});

        // Write vs rd0 at the same address
        da = rnd128();
        do_cycle(1, 7'd12, da, 8'hFF, 1, 7'd12, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t3_wr_ready", wr_ready, 1'b1);
        check("t3_rd0_stall", rd0_ready, 1'b0);
        do_cycle(0, 0, 0, 0, 1, 7'd12, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t3_rd0_retry", rd0_ready, 1'b1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t3_rdata", d0, da);

        // rd1 vs rd0 at the same address
        db = rnd128();
        do_cycle(1, 7'd20, db, 8'hFF, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        do_cycle(0, 0, 0, 0, 1, 7'd20, 1, 7'd20, 0, gw, g0, g1, d0, d1);
        check("t4_rd0_ready", rd0_ready, 1'b1);
        check("t4_rd1_stall", rd1_ready, 1'b0);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 7'd20, 0, gw, g0, g1, d0, d1);
        check("t4_rd1_retry", rd1_ready, 1'b1);
        check("t4_rd0_data", d0, db);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t4_rd1_data", d1, db);

        // Writer streak limit with rd1 waiting
        mw = 0; dut_wr = 0; grant_at = -1; r1p = 1;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1, 7'(30 + mw), {4{32'(30 + mw)}}, 8'hFF, 0, 0, r1p, 7'd50, 0,
                     gw, g0, g1, d0, d1);
            if (wr_ready) dut_wr++;
            if (rd1_ready && grant_at < 0) grant_at = i;
            if (gw) mw++;
            if (g1) r1p = 0;
        end
        check("t5_rd1_grant_cycle", 32'(grant_at), 32'd4);
        check("t5_write_grants", 32'(dut_wr), 32'd9);

        // Full clear, with a stray clr_start mid-sweep
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, gw, g0, g1, d0, d1);
        busy_cnt = 0; done_addr = -1;
        for (int i = 0; i < 140; i++) begin
            do_cycle(0, 0, 0, 0, 0, 0, 0, 0, i == 10, gw, g0, g1, d0, d1);
            if (busy) busy_cnt++;
            if (clr_done) done_addr = int'(sram_a);
        end
        check("t6_busy_cycles", 32'(busy_cnt), 32'd128);
        check("t6_done_addr", 32'(done_addr), 32'd127);
        for (int i = 0; i <= 64; i++) begin
            do_cycle(0, 0, 0, 0, i < 64, 7'(i), i < 64, 7'(i + 64), 0, gw, g0, g1, d0, d1);
            if (i > 0) begin
                check("t6_zero_rd0", d0, 128'(0));
                check("t6_zero_rd1", d1, 128'(0));
            end
        end

        // Randomized traffic on a narrow address window to provoke collisions
        pw = 0; p0 = 0; p1 = 0; pwa = 0; p0a = 0; p1a = 0; pwd = 0; pws = 0;
        for (int it = 0; it < 500; it++) begin
            if (!pw && $urandom_range(0, 3) != 0) begin
                pw = 1; pwa = 7'($urandom_range(0, 7)); pwd = rnd128(); pws = 8'($urandom);
            end
            if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1; p0a = 7'($urandom_range(0, 7)); end
            if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1; p1a = 7'($urandom_range(0, 7)); end
            do_cycle(pw, pwa, pwd, pws, p0, p0a, p1, p1a, 0, gw, g0, g1, d0, d1);
            if (gw) pw = 0;
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);

        // Reset in the middle of a clear
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, gw, g0, g1, d0, d1);
        for (int i = 0; i < 40; i++)
            do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        @(negedge clk);
        check("t7_busy_before", busy, 1'b1);
        check("t7_clear_addr", sram_a, 7'd40);
        rst_n = 0;
        #1;
        check("t7_busy_reset", busy, 1'b0);
        check("t7_done_reset", clr_done, 1'b0);
        check("t7_wean_reset", sram_wean, 8'hFF);
        m_clear = 0; m_cnt = 0; writes_while_rd1_waits = 0; er0_v = 0; er1_v = 0;
        repeat (2) begin
            @(negedge clk);
            check("t7_no_done", clr_done, 1'b0);
        end
        rst_n = 1;
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gw, g0, g1, d0, d1);
        check("t7_idle_after", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
